playlist_player_ctrl: RTL and testbench
=======================================

# playlist_player_ctrl

Parametrised playback controller for the music player: tracks the current song index and beat position across a playlist of `NUM_SONGS` songs, each with its own length. It handles play/pause/stop, seek, next/previous song, direct song select, and four repeat modes. It sits between the button debounce/one-pulse logic and the note ROM/tone generator, and replaces the fixed four-song controller. It runs on one system clock; beat advance is gated by a beat-rate strobe instead of a second clock domain.

## Interface
- `NUM_SONGS`, 4: songs in playlist, 2..16; `SONG_W = $clog2(NUM_SONGS)` derived
- `BEAT_W`, 8: beat counter width
- `SKIP_BEATS`, 8: seek step in beats, < 2^BEAT_W

- `clk` in 1: system clock, all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `beat_tick` in 1: one-cycle strobe at beat rate
- `play_pause` in 1: one-cycle pulse, toggles play/pause
- `stop` in 1: one-cycle pulse, returns to IDLE
- `next_song`, `prev_song` in 1: one-cycle pulses
- `forward`, `backward` in 1: one-cycle seek pulses
- `song_sel_valid` in 1: load `song_sel`
- `song_sel` in SONG_W: direct song index
- `repeat_mode` in 2: 0 off, 1 repeat-one, 2 repeat-all, 3 play-through
- `song_lens` in NUM_SONGS*BEAT_W: last beat index per song, song k at `[k*BEAT_W +: BEAT_W]`
- `ibeat` out BEAT_W: current beat
- `song_idx` out SONG_W: current song
- `ispause` out 1: 1 when not playing
- `song_finished` out 1: one-cycle pulse at end of song
- `playlist_done` out 1: one-cycle pulse at end of playlist

## Operation
- States: IDLE, PLAY, PAUSE. All outputs are registered. `ispause` = 1 in IDLE and PAUSE.
- `len` = `song_lens` slice for `song_idx`.
- Event priority, one event per cycle: `stop` > `song_sel_valid` > `next_song`/`prev_song` > `play_pause` > seek > beat advance.
- `stop`: any state goes to IDLE with `ibeat` = 0; `song_idx` is kept.
- `song_sel_valid`:
  - If `song_sel` < NUM_SONGS: `song_idx` = `song_sel`, `ibeat` = 0, state unchanged.
  - Otherwise the select is ignored.
- `next_song`: `song_idx` + 1, wrapping NUM_SONGS-1 to 0. `prev_song`: `song_idx` - 1, wrapping 0 to NUM_SONGS-1. Both set `ibeat` = 0 and leave the state unchanged. If both are asserted, both are ignored.
- `play_pause`:
  - IDLE to PLAY with `ibeat` = 0.
  - PLAY to PAUSE; PAUSE to PLAY. `ibeat` is held in both cases.
- Seek is honoured in PLAY and PAUSE only:
  - `forward`: `ibeat` = min(`ibeat` + SKIP_BEATS, `len`). The sum is computed in BEAT_W+1 bits, so it never wraps.
  - `backward`: `ibeat` = max(`ibeat` - SKIP_BEATS, 0).
  - If both are asserted, both are ignored.
- Beat advance happens in PLAY on `beat_tick`:
  - If `ibeat` != `len`: `ibeat` + 1.
  - If `ibeat` == `len`: pulse `song_finished` and set `ibeat` = 0, then act by `repeat_mode`:
    - 0: go to IDLE.
    - 1: stay in PLAY on the same song.
    - 2: `song_idx` + 1 with wrap, stay in PLAY; pulse `playlist_done` when wrapping from the last song.
    - 3: if not the last song, `song_idx` + 1 and stay in PLAY; on the last song, go to IDLE with `song_idx` = 0 and pulse `playlist_done`.
- If `len` changes below the current `ibeat`, the next tick is treated as end of song.

## Timing
- Reset values: state IDLE, `ibeat` 0, `song_idx` 0, `ispause` 1, `song_finished` 0, `playlist_done` 0.
- Inputs are sampled at a clock edge; the result is visible on outputs one cycle later.
- `song_finished` and `playlist_done` are exactly one cycle wide, and both are asserted in the same cycle as `ibeat` returning to 0.
- A `beat_tick` coinciding with any higher-priority event is dropped, not deferred.
- A reset mid-play aborts immediately to reset values; no pulse is emitted.

## Configuration
- `PLAYLIST_SHUFFLE_EN` defined:
  - Adds input `shuffle_on` (1 bit).
  - A free-running 16-bit Fibonacci LFSR (taps 16,14,13,11, reset seed 16'hACE1) advances every cycle.
  - When `shuffle_on` = 1, song advance by `next_song` and repeat modes 2/3 picks `lfsr % NUM_SONGS`; if that equals `song_idx`, it uses `song_idx` + 1 with wrap instead.
  - Mode 3 counts completed songs and ends the playlist after NUM_SONGS completions (IDLE, `playlist_done`).
  - `prev_song` is unaffected.
- Undefined: no port, no LFSR; sequential order only.

## Test plan
- Reset, then `play_pause`, then 5 `beat_tick`s -> `ispause` 0, `ibeat` 5, `song_idx` 0.
- `song_lens` song0 = 10, `ibeat` 6, `forward` -> `ibeat` 10; then `backward` twice -> 2, then 0.
- Mode 2, NUM_SONGS 4, `song_idx` 3 at `len`, `beat_tick` -> `song_finished` and `playlist_done` pulse for one cycle, `song_idx` 0, `ibeat` 0, still PLAY.
- Mode 3 on song 3 at end -> IDLE, `ispause` 1, `song_idx` 0, `playlist_done` 1 cycle; mode 0 on song 1 -> IDLE, `song_idx` 1, no `playlist_done`.
- PAUSE at `ibeat` 7: `beat_tick` x3 -> `ibeat` 7; `play_pause` together with `beat_tick` -> PLAY, `ibeat` 7; `song_sel_valid` with `song_sel` 5 (NUM_SONGS 4) -> ignored.
- `stop` with `next_song` and `beat_tick` in the same cycle -> IDLE, `ibeat` 0, `song_idx` unchanged; reset pulse mid-PLAY -> all reset values.

Source files
------------

// File: rtl/playlist_player_ctrl.sv
// Playback controller: song index, beat position, play/pause/stop, seek, skip and repeat modes.
// Optional shuffle support is enabled by defining PLAYLIST_SHUFFLE_EN.
module playlist_player_ctrl #(
  parameter  int NUM_SONGS  = 4,
  parameter  int BEAT_W     = 8,
  parameter  int SKIP_BEATS = 8,
  localparam int SONG_W     = $clog2(NUM_SONGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        beat_tick,
  input  logic                        play_pause,
  input  logic                        stop,
  input  logic                        next_song,
  input  logic                        prev_song,
  input  logic                        forward,
  input  logic                        backward,
  input  logic                        song_sel_valid,
  input  logic [SONG_W-1:0]           song_sel,
  input  logic [1:0]                  repeat_mode,
`ifdef PLAYLIST_SHUFFLE_EN
  input  logic                        shuffle_on,
`endif
  input  logic [NUM_SONGS*BEAT_W-1:0] song_lens,
  output logic [BEAT_W-1:0]           ibeat,
  output logic [SONG_W-1:0]           song_idx,
  output logic                        ispause,
  output logic                        song_finished,
  output logic                        playlist_done
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_e;

  localparam logic [SONG_W:0]   NUM_SONGS_EXT = (SONG_W+1)'(NUM_SONGS);
  localparam logic [SONG_W-1:0] LAST_SONG     = SONG_W'(NUM_SONGS - 1);
  localparam logic [BEAT_W:0]   SKIP_EXT      = (BEAT_W+1)'(SKIP_BEATS);
  localparam logic [BEAT_W-1:0] SKIP_NARROW   = BEAT_W'(SKIP_BEATS);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   ibeat_q, ibeat_d;
  logic [SONG_W-1:0]   song_idx_q, song_idx_d;
  logic                ispause_q, fin_q, fin_d, done_q, done_d;

  logic [BEAT_W-1:0]   lens [NUM_SONGS];
  logic [BEAT_W-1:0]   len;
  logic [BEAT_W:0]     fwd_sum;
  logic [SONG_W-1:0]   seq_next, seq_prev, adv_idx;

  for (genvar k = 0; k < NUM_SONGS; k++) begin : g_lens
    assign lens[k] = song_lens[k*BEAT_W +: BEAT_W];
  end

  assign len      = lens[song_idx_q];
  assign fwd_sum  = {1'b0, ibeat_q} + SKIP_EXT;
  assign seq_next = (song_idx_q == LAST_SONG) ? '0 : song_idx_q + 1'b1;
  assign seq_prev = (song_idx_q == '0) ? LAST_SONG : song_idx_q - 1'b1;

`ifdef PLAYLIST_SHUFFLE_EN
  logic [15:0]     lfsr_q;
  logic [SONG_W:0] cnt_q, cnt_d;
  logic [SONG_W-1:0] pick;

  assign pick    = SONG_W'(lfsr_q % NUM_SONGS);
  assign adv_idx = (shuffle_on && pick != song_idx_q) ? pick : seq_next;

  // Fibonacci taps 16,14,13,11; free-running regardless of playback state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`else
  assign adv_idx = seq_next;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    ibeat_d    = ibeat_q;
    song_idx_d = song_idx_q;
    fin_d      = 1'b0;
    done_d     = 1'b0;
`ifdef PLAYLIST_SHUFFLE_EN
    cnt_d      = cnt_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
      ibeat_d = '0;
    end else if (song_sel_valid && ({1'b0, song_sel} < NUM_SONGS_EXT)) begin
      song_idx_d = song_sel;
      ibeat_d    = '0;
    end else if (next_song != prev_song) begin
      song_idx_d = next_song ? adv_idx : seq_prev;
      ibeat_d    = '0;
    end else if (play_pause) begin
      unique case (state_q)
        S_IDLE:  begin state_d = S_PLAY; ibeat_d = '0; end
        S_PLAY:  state_d = S_PAUSE;
        default: state_d = S_PLAY;
      endcase
    end else if (state_q != S_IDLE && forward != backward) begin
      if (forward) ibeat_d = (fwd_sum > {1'b0, len}) ? len : fwd_sum[BEAT_W-1:0];
      else         ibeat_d = (ibeat_q >= SKIP_NARROW) ? ibeat_q - SKIP_NARROW : '0;
    end else if (state_q == S_PLAY && beat_tick) begin
      // ">=" so a length shortened below the current beat ends the song on this tick.
      if (ibeat_q < len) begin
        ibeat_d = ibeat_q + 1'b1;
      end else begin
        fin_d   = 1'b1;
        ibeat_d = '0;
        unique case (repeat_mode)
          2'd0: state_d = S_IDLE;
          2'd1: ;
          2'd2: begin
            song_idx_d = adv_idx;
            done_d     = (song_idx_q == LAST_SONG);
          end
          default: begin
`ifdef PLAYLIST_SHUFFLE_EN
            if (shuffle_on) begin
              if (cnt_q == NUM_SONGS_EXT - 1'b1) begin
                state_d = S_IDLE; song_idx_d = '0; done_d = 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1; song_idx_d = adv_idx;
              end
            end else
`endif
            if (song_idx_q == LAST_SONG) begin
              state_d = S_IDLE; song_idx_d = '0; done_d = 1'b1;
            end else begin
              song_idx_d = seq_next;
            end
          end
        endcase
      end
    end
`ifdef PLAYLIST_SHUFFLE_EN
    if (state_d == S_IDLE) cnt_d = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ibeat_q    <= '0;
      song_idx_q <= '0;
      ispause_q  <= 1'b1;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef PLAYLIST_SHUFFLE_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ibeat_q    <= ibeat_d;
      song_idx_q <= song_idx_d;
      ispause_q  <= (state_d != S_PLAY);
      fin_q      <= fin_d;
      done_q     <= done_d;
`ifdef PLAYLIST_SHUFFLE_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign ibeat         = ibeat_q;
  assign song_idx      = song_idx_q;
  assign ispause       = ispause_q;
  assign song_finished = fin_q;
  assign playlist_done = done_q;

endmodule

// File: tb/tb_playlist_player_ctrl.sv
// Self-checking bench for playlist_player_ctrl: directed scenarios plus randomized traffic
// against a behavioural model. Five songs so out-of-range selects are representable.
module tb_playlist_player_ctrl;

  localparam int N    = 5;
  localparam int BW   = 8;
  localparam int SKIP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          beat_tick, play_pause, stop, next_song, prev_song;
  logic          forward, backward, song_sel_valid;
  logic [2:0]    song_sel;
  logic [1:0]    repeat_mode;
  logic [N*BW-1:0] song_lens;
  logic [BW-1:0] ibeat;
  logic [2:0]    song_idx;
  logic          ispause, song_finished, playlist_done;

  int errors = 0;
  int checks = 0;
  int lens [N];

  // Model: 0 idle, 1 play, 2 pause
  int m_st, m_beat, m_song, m_fin, m_done;

  playlist_player_ctrl #(.NUM_SONGS(N), .BEAT_W(BW), .SKIP_BEATS(SKIP)) dut (
    .clk(clk), .reset(reset), .beat_tick(beat_tick), .play_pause(play_pause),
    .stop(stop), .next_song(next_song), .prev_song(prev_song),
    .forward(forward), .backward(backward), .song_sel_valid(song_sel_valid),
    .song_sel(song_sel), .repeat_mode(repeat_mode), .song_lens(song_lens),
    .ibeat(ibeat), .song_idx(song_idx), .ispause(ispause),
    .song_finished(song_finished), .playlist_done(playlist_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

  task automatic pack_lens();
    for (int k = 0; k < N; k++) song_lens[k*BW +: BW] = lens[k][BW-1:0];
  endtask

  task automatic clear_pulses();
    beat_tick = 0; play_pause = 0; stop = 0; next_song = 0; prev_song = 0;
    forward = 0; backward = 0; song_sel_valid = 0;
  endtask

  // One clock: inputs already set at the falling edge; sample after the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin beat_tick = 1; cyc(); end
  endtask

  task automatic apply_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (ispause !== 1'b1 || ibeat !== 8'd0 || song_idx !== 3'd0 ||
        song_finished !== 1'b0 || playlist_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: pause=%0b beat=%0d song=%0d fin=%0b done=%0b want 1 0 0 0 0",
               ispause, ibeat, song_idx, song_finished, playlist_done);
    end
  endtask

  task automatic test_play_beats();
    play_pause = 1; cyc();
    ticks(5);
    checks++;
    if (ispause !== 1'b0 || ibeat !== 8'd5 || song_idx !== 3'd0) begin
      errors++;
      $display("FAIL play_beats: pause=%0b beat=%0d song=%0d want 0 5 0", ispause, ibeat, song_idx);
    end
  endtask

  task automatic test_seek();
    ticks(1);
    checks++;
    if (ibeat !== 8'd6) begin errors++; $display("FAIL seek_pre: beat=%0d want 6", ibeat); end
    forward = 1; cyc();
    checks++;
    if (ibeat !== 8'd10) begin errors++; $display("FAIL seek_fwd_clamp: beat=%0d want 10", ibeat); end
    backward = 1; cyc();
    checks++;
    if (ibeat !== 8'd2) begin errors++; $display("FAIL seek_back: beat=%0d want 2", ibeat); end
    backward = 1; cyc();
    checks++;
    if (ibeat !== 8'd0) begin errors++; $display("FAIL seek_back_floor: beat=%0d want 0", ibeat); end
  endtask

  task automatic test_repeat_all();
    repeat_mode = 2'd2;
    song_sel = 3'd4; song_sel_valid = 1; cyc();
    checks++;
    if (song_idx !== 3'd4 || ibeat !== 8'd0 || ispause !== 1'b0) begin
      errors++;
      $display("FAIL select: song=%0d beat=%0d pause=%0b want 4 0 0", song_idx, ibeat, ispause);
    end
    ticks(3);
    checks++;
    if (song_finished !== 1'b1 || playlist_done !== 1'b1 || song_idx !== 3'd0 ||
        ibeat !== 8'd0 || ispause !== 1'b0) begin
      errors++;
      $display("FAIL repeat_all_wrap: fin=%0b done=%0b song=%0d beat=%0d pause=%0b want 1 1 0 0 0",
               song_finished, playlist_done, song_idx, ibeat, ispause);
    end
    cyc();
    checks++;
    if (song_finished !== 1'b0 || playlist_done !== 1'b0 || ibeat !== 8'd0) begin
      errors++;
      $display("FAIL pulse_width: fin=%0b done=%0b beat=%0d want 0 0 0",
               song_finished, playlist_done, ibeat);
    end
  endtask

  task automatic test_play_through();
    repeat_mode = 2'd3;
    song_sel = 3'd4; song_sel_valid = 1; cyc();
    ticks(3);
    checks++;
    if (ispause !== 1'b1 || song_idx !== 3'd0 || song_finished !== 1'b1 ||
        playlist_done !== 1'b1 || ibeat !== 8'd0) begin
      errors++;
      $display("FAIL play_through_end: pause=%0b song=%0d fin=%0b done=%0b beat=%0d want 1 0 1 1 0",
               ispause, song_idx, song_finished, playlist_done, ibeat);
    end
    cyc();
    checks++;
    if (playlist_done !== 1'b0) begin errors++; $display("FAIL done_width: done=%0b want 0", playlist_done); end
    repeat_mode = 2'd0;
    play_pause = 1; cyc();
    song_sel = 3'd1; song_sel_valid = 1; cyc();
    ticks(4);
    checks++;
    if (ispause !== 1'b1 || song_idx !== 3'd1 || song_finished !== 1'b1 || playlist_done !== 1'b0) begin
      errors++;
      $display("FAIL mode0_end: pause=%0b song=%0d fin=%0b done=%0b want 1 1 1 0",
               ispause, song_idx, song_finished, playlist_done);
    end
  endtask

  task automatic test_pause_hold();
    song_sel = 3'd0; song_sel_valid = 1; cyc();
    play_pause = 1; cyc();
    ticks(7);
    play_pause = 1; cyc();
    ticks(3);
    checks++;
    if (ispause !== 1'b1 || ibeat !== 8'd7) begin
      errors++;
      $display("FAIL pause_hold: pause=%0b beat=%0d want 1 7", ispause, ibeat);
    end
    play_pause = 1; beat_tick = 1; cyc();
    checks++;
    if (ispause !== 1'b0 || ibeat !== 8'd7) begin
      errors++;
      $display("FAIL resume_drop_tick: pause=%0b beat=%0d want 0 7", ispause, ibeat);
    end
    song_sel = 3'd5; song_sel_valid = 1; cyc();
    checks++;
    if (song_idx !== 3'd0 || ibeat !== 8'd7) begin
      errors++;
      $display("FAIL bad_select: song=%0d beat=%0d want 0 7", song_idx, ibeat);
    end
  endtask

  task automatic test_stop_priority();
    ticks(1);
    stop = 1; next_song = 1; beat_tick = 1; cyc();
    checks++;
    if (ispause !== 1'b1 || ibeat !== 8'd0 || song_idx !== 3'd0) begin
      errors++;
      $display("FAIL stop_priority: pause=%0b beat=%0d song=%0d want 1 0 0", ispause, ibeat, song_idx);
    end
    play_pause = 1; cyc();
    next_song = 1; cyc();
    ticks(3);
    checks++;
    if (song_idx !== 3'd1 || ibeat !== 8'd3 || ispause !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: song=%0d beat=%0d pause=%0b want 1 3 0", song_idx, ibeat, ispause);
    end
    beat_tick = 1;
    reset = 0;
    #2;
    checks++;
    if (ispause !== 1'b1 || ibeat !== 8'd0 || song_idx !== 3'd0 ||
        song_finished !== 1'b0 || playlist_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pause=%0b beat=%0d song=%0d fin=%0b done=%0b want 1 0 0 0 0",
               ispause, ibeat, song_idx, song_finished, playlist_done);
    end
    @(negedge clk);
    clear_pulses();
    reset = 1;
    @(negedge clk);
  endtask

  task automatic model_step();
    int len;
    len = lens[m_song];
    m_fin = 0; m_done = 0;
    if (stop) begin
      m_st = 0; m_beat = 0;
    end else if (song_sel_valid && int'(song_sel) < N) begin
      m_song = int'(song_sel); m_beat = 0;
    end else if (next_song && !prev_song) begin
      m_song = (m_song + 1) % N; m_beat = 0;
    end else if (prev_song && !next_song) begin
      m_song = (m_song + N - 1) % N; m_beat = 0;
    end else if (play_pause) begin
      if (m_st == 0) begin m_st = 1; m_beat = 0; end
      else m_st = (m_st == 1) ? 2 : 1;
    end else if (m_st != 0 && forward && !backward) begin
      m_beat = (m_beat + SKIP > len) ? len : m_beat + SKIP;
    end else if (m_st != 0 && backward && !forward) begin
      m_beat = (m_beat - SKIP < 0) ? 0 : m_beat - SKIP;
    end else if (m_st == 1 && beat_tick) begin
      if (m_beat < len) m_beat++;
      else begin
        m_fin = 1; m_beat = 0;
        case (repeat_mode)
          2'd0: m_st = 0;
          2'd1: ;
          2'd2: begin m_done = (m_song == N-1); m_song = (m_song + 1) % N; end
          default: begin
            if (m_song == N-1) begin m_st = 0; m_song = 0; m_done = 1; end
            else m_song++;
          end
        endcase
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    m_st = 0; m_beat = 0; m_song = 0; m_fin = 0; m_done = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        lens[$urandom_range(0, N-1)] = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 30);
        pack_lens();
      end
      if ($urandom_range(0, 99) < 4) repeat_mode = 2'($urandom_range(0, 3));
      stop           = ($urandom_range(0, 99) < 2);
      song_sel_valid = ($urandom_range(0, 99) < 4);
      song_sel       = 3'($urandom_range(0, 7));
      next_song      = ($urandom_range(0, 99) < 4);
      prev_song      = ($urandom_range(0, 99) < 4);
      play_pause     = ($urandom_range(0, 99) < 8);
      forward        = ($urandom_range(0, 99) < 10);
      backward       = ($urandom_range(0, 99) < 5);
      beat_tick      = ($urandom_range(0, 99) < 60);
      model_step();
      cyc();
      checks++;
      if (ibeat !== BW'(m_beat) || song_idx !== 3'(m_song) || ispause !== (m_st != 1) ||
          song_finished !== 1'(m_fin) || playlist_done !== 1'(m_done)) begin
        errors++;
        $display("FAIL random[%0d]: beat=%0d song=%0d pause=%0b fin=%0b done=%0b want %0d %0d %0b %0d %0d",
                 c, ibeat, song_idx, ispause, song_finished, playlist_done,
                 m_beat, m_song, (m_st != 1), m_fin, m_done);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_pulses();
    song_sel = '0;
    repeat_mode = 2'd0;
    lens[0] = 10; lens[1] = 3; lens[2] = 5; lens[3] = 4; lens[4] = 2;
    pack_lens();
    @(negedge clk);
    test_reset();
    test_play_beats();
    test_seek();
    test_repeat_all();
    test_play_through();
    test_pause_hold();
    test_stop_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
